// File: rtl/wave_serial_dac_tx.sv
// Serial DAC output stage: one-deep sample holding register feeding an MSB-first shifter
// that emits contiguous frames of WAVE_DEPTH data bits followed by one latch bit period.
module wave_serial_dac_tx #(
    parameter int unsigned WAVE_DEPTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WAVE_DEPTH-1:0] Sample,
    input  logic                  SampleValid,
    output logic                  SampleReady,
    output logic                  SerClk,
    output logic                  SerData,
    output logic                  SerLatch,
    output logic                  Underrun
);

    localparam int unsigned DivW = ($clog2(2 * CLK_DIV) > 0) ? $clog2(2 * CLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(WAVE_DEPTH + 1);

    localparam logic [DivW-1:0] DivLast = DivW'(2 * CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV);
    localparam logic [BitW-1:0] BitLast = BitW'(WAVE_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    state_e                state_q, state_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [WAVE_DEPTH-1:0] shift_q, shift_d;
    logic [WAVE_DEPTH-1:0] last_q, last_d;
    logic [WAVE_DEPTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  ready_q, ready_d;
    logic                  ser_clk_q, ser_clk_d;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_latch_q, ser_latch_d;
    logic                  underrun_q, underrun_d;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;

        case (state_q)
            StIdle: begin
                div_d = '0;
                bit_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    last_d      = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = StShift;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == BitLast) begin
                        state_d = StLatch;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StLatch: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StShift;
                    // Frame boundary: fresh sample if one is waiting, otherwise repeat.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        last_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d    = last_q;
                        underrun_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Uses the registered ready, so an accept never feeds a same-edge load.
        if (SampleValid && ready_q) begin
            hold_d      = Sample;
            hold_full_d = 1'b1;
        end

        ready_d     = ~hold_full_d;
        ser_clk_d   = (state_d == StShift) && (div_d >= DivHalf);
        ser_data_d  = (state_d == StShift) && shift_d[WAVE_DEPTH-1];
        ser_latch_d = (state_d == StLatch);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            ser_clk_q   <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_latch_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            ser_clk_q   <= ser_clk_d;
            ser_data_q  <= ser_data_d;
            ser_latch_q <= ser_latch_d;
            underrun_q  <= underrun_d;
        end
    end

    assign SampleReady = ready_q;
    assign SerClk      = ser_clk_q;
    assign SerData     = ser_data_q;
    assign SerLatch    = ser_latch_q;
    assign Underrun    = underrun_q;

endmodule

// File: tb/tb_wave_serial_dac_tx.sv
// Bench for wave_serial_dac_tx: frame-level reference model feeds a scoreboard queue that a
// serial-link monitor drains as it decodes words from SerClk/SerData/SerLatch.
module tb_wave_serial_dac_tx;

    localparam int W  = 8;
    localparam int CD = 4;
    localparam int BP = 2 * CD;
    localparam int FL = (W + 1) * BP;

    typedef struct packed {
        logic [7:0] w;
        logic       u;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       valid = 1'b0;
    logic       ready, sclk, sdata, slatch, underrun;

    logic [7:0] sample1 = 8'hFF;
    logic       valid1 = 1'b0;
    logic       ready1, sclk1, sdata1, slatch1, underrun1;

    wave_serial_dac_tx #(.WAVE_DEPTH(W), .CLK_DIV(CD)) u_dut (
        .Clock(clk), .Reset(rst_n), .Sample(sample), .SampleValid(valid),
        .SampleReady(ready), .SerClk(sclk), .SerData(sdata), .SerLatch(slatch),
        .Underrun(underrun)
    );

    wave_serial_dac_tx #(.WAVE_DEPTH(W), .CLK_DIV(1)) u_dut_div1 (
        .Clock(clk), .Reset(rst_n), .Sample(sample1), .SampleValid(valid1),
        .SampleReady(ready1), .SerClk(sclk1), .SerData(sdata1), .SerLatch(slatch1),
        .Underrun(underrun1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: frames start back to back every FL cycles once streaming; the
    // boundary load takes the held sample if it was held before the boundary cycle.
    frame_t     exp_q[$];
    frame_t     hist[$];
    bit         m_stream = 0;
    bit         m_full = 0;
    bit         m_ur_exp = 0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_last = 8'h00;
    int         m_next = 0;

    initial forever begin
        bit     acc;
        bit     load;
        frame_t f;
        @(negedge clk);
        if (!rst_n) begin
            m_stream = 0;
            m_full   = 0;
            m_ur_exp = 0;
            m_last   = 8'h00;
            m_next   = 0;
            exp_q.delete();
            chk("reset_outputs", {sclk, sdata, slatch, underrun, ready}, 5'b00001);
        end else begin
            chk("ready", ready, !m_full);
            chk("underrun", underrun, m_ur_exp);
            acc      = valid && !m_full;
            load     = m_stream ? (cyc + 1 == m_next) : m_full;
            m_ur_exp = 0;
            if (load) begin
                if (m_full) begin
                    f.w    = m_hold;
                    f.u    = 1'b0;
                    m_last = m_hold;
                    m_full = 0;
                end else begin
                    f.w      = m_last;
                    f.u      = 1'b1;
                    m_ur_exp = 1;
                end
                exp_q.push_back(f);
                m_stream = 1;
                m_next   = cyc + 1 + FL;
            end
            if (acc) begin
                m_hold = sample;
                m_full = 1;
            end
        end
    end

    // Link monitor: decodes what the DAC would see and checks it against the scoreboard.
    bit         mon_prev_clk = 0;
    bit         mon_prev_latch = 0;
    bit         mon_ur = 0;
    logic [7:0] mon_word = 8'h00;
    int         mon_bits = 0;
    int         mon_latch_len = 0;
    int         mon_last_rise = -1;
    int         first_rise = -1;

    initial forever begin
        frame_t f;
        @(negedge clk);
        if (!rst_n) begin
            mon_prev_clk   = 0;
            mon_prev_latch = 0;
            mon_ur         = 0;
            mon_bits       = 0;
            mon_latch_len  = 0;
            mon_last_rise  = -1;
            first_rise     = -1;
        end else begin
            if (underrun) mon_ur = 1;
            if (sclk && !mon_prev_clk) begin
                mon_word = {mon_word[6:0], sdata};
                mon_bits++;
                if (first_rise < 0) first_rise = cyc;
            end
            if (slatch && !mon_prev_latch) begin
                chk("bit_count", mon_bits, W);
                if (mon_last_rise >= 0) chk("frame_len", cyc - mon_last_rise, FL);
                mon_last_rise = cyc;
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    chk("frame_word", mon_word, f.w);
                    chk("frame_underrun", mon_ur, f.u);
                end
                f = {mon_word, mon_ur};
                hist.push_back(f);
                mon_bits      = 0;
                mon_ur        = 0;
                mon_latch_len = 0;
            end
            if (slatch) mon_latch_len++;
            if (!slatch && mon_prev_latch) chk("latch_len", mon_latch_len, BP);
            mon_prev_clk   = sclk;
            mon_prev_latch = slatch;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
    endtask

    task automatic send(input logic [7:0] v, input bit keep, output int ca);
        int k;
        k = 0;
        @(posedge clk);
        #1 sample = v;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", ready, 1);
        ca = cyc;
        @(posedge clk);
        #1 if (!keep) valid = 1'b0;
    endtask

    task automatic wait_hist(input int n, input int budget);
        int k;
        k = 0;
        while (hist.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("frame_timeout", (hist.size() >= n), 1);
    endtask

    task automatic check_hist(input int idx, input logic [7:0] w, input logic u,
                              input string tag);
        if (hist.size() > idx) begin
            chk({tag, "_word"}, hist[idx].w, w);
            chk({tag, "_underrun"}, hist[idx].u, u);
        end else begin
            chk({tag, "_missing"}, hist.size(), idx + 1);
        end
    endtask

    int         ca;
    int         c1;
    int         base;
    int         k;
    logic [3:0] e;
    logic [7:0] rv;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // CLK_DIV=1 instance, 0xFF: 16 toggling bit cycles then 2 latch cycles
        @(posedge clk);
        #1 valid1 = 1'b1;
        @(negedge clk);
        chk("div1_ready_idle", ready1, 1);
        c1 = cyc;
        @(posedge clk);
        #1 valid1 = 1'b0;
        @(negedge clk);
        chk("div1_ready_held", ready1, 0);
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            e[3] = (j < 16) && (j % 2 == 1);
            e[2] = (j < 16);
            e[1] = (j >= 16);
            e[0] = 1'b0;
            chk("div1_frame", {sclk1, sdata1, slatch1, underrun1}, e);
        end
        @(negedge clk);
        chk("div1_repeat", {sclk1, sdata1, slatch1, underrun1}, 4'b0101);
        chk("div1_frame_len", cyc - (c1 + 2), 18);

        // Single 0xA5 after reset: latency, bit order, then a repeat
        do_reset();
        send(8'hA5, 1'b0, ca);
        wait_hist(2, 300);
        check_hist(0, 8'hA5, 1'b0, "a5_first");
        check_hist(1, 8'hA5, 1'b1, "a5_repeat");
        chk("a5_first_rise", first_rise - ca, 6);

        // 0x81 once, then idle producer: repeats with underrun each boundary
        do_reset();
        send(8'h81, 1'b0, ca);
        wait_hist(3, 400);
        check_hist(0, 8'h81, 1'b0, "x81_f0");
        check_hist(1, 8'h81, 1'b1, "x81_f1");
        check_hist(2, 8'h81, 1'b1, "x81_f2");

        // Streaming producer followed by a random sample
        do_reset();
        rv = 8'($urandom_range(0, 255));
        send(8'h00, 1'b1, ca);
        send(8'hFF, 1'b1, ca);
        send(8'h3C, 1'b1, ca);
        send(rv, 1'b0, ca);
        wait_hist(5, 700);
        check_hist(0, 8'h00, 1'b0, "stream_f0");
        check_hist(1, 8'hFF, 1'b0, "stream_f1");
        check_hist(2, 8'h3C, 1'b0, "stream_f2");
        check_hist(3, rv, 1'b0, "stream_rand");
        check_hist(4, rv, 1'b1, "stream_repeat");

        // A few randomly spaced random samples, checked by the scoreboard alone
        for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 150)) @(posedge clk);
            send(8'($urandom_range(0, 255)), 1'b0, ca);
        end
        base = hist.size();
        wait_hist(base + 2, 300);

        // Accept on the last LATCH cycle with the holding register empty
        k = 0;
        do begin
            @(posedge clk);
            #2 k++;
        end while (cyc != m_next - 1 && k < 200);
        chk("edge_align", cyc, m_next - 1);
        sample = 8'h55;
        valid  = 1'b1;
        base   = hist.size();
        @(posedge clk);
        #1 valid = 1'b0;
        wait_hist(base + 2, 300);
        if (hist.size() > base + 1) begin
            chk("edge_repeat_underrun", hist[base].u, 1);
            chk("edge_new_word", hist[base + 1].w, 8'h55);
            chk("edge_new_underrun", hist[base + 1].u, 0);
        end

        // Asynchronous reset in the middle of bit 3 of a 0x55 frame
        k = 0;
        do begin
            @(posedge clk);
            #2 k++;
        end while (cyc - (m_next - FL) != 27 && k < 200);
        chk("midframe_data", sdata, 1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {sclk, sdata, slatch, underrun, ready}, 5'b00001);
        chk("async_reset_div1", {sclk1, sdata1, slatch1, underrun1, ready1}, 5'b00001);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            chk("idle_after_reset", {sclk, slatch, ready}, 3'b001);
        end
        chk("idle_no_frames", hist.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
